// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer.
package mac_seq_pkg;

  localparam int unsigned OPW        = 8;   // operand width
  localparam int unsigned PRODW      = 16;  // multiplier product width
  localparam int unsigned WDOG_LIMIT = 63;  // WAIT cycles before a term is aborted

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStart,
    StWait,
    StAcc,
    StDone
  } state_e;

endpackage

// File: rtl/mac_watchdog.sv
// WAIT-state timeout counter; used only when MAC_WATCHDOG_EN is defined.
module mac_watchdog
  import mac_seq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [5:0] Limit = 6'(WDOG_LIMIT);

  logic [5:0] r_cnt;

  // Count enabled cycles, saturating at the limit; cleared outside WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != Limit)) begin
      r_cnt <= r_cnt + 6'd1;
    end
  end

  assign o_timeout = i_en && (r_cnt == Limit);

endmodule

// File: rtl/mac_sequencer.sv
// Operand sequencer and dot-product accumulator for the Booth multiplier.
// Optional feature: define MAC_WATCHDOG_EN to abort terms whose multiply never completes.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned N_MAX = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_x,
  input  logic [OPW-1:0]   in_y,
  input  logic             in_last,
  output logic             mul_reset,
  output logic             mul_start,
  output logic [OPW-1:0]   mul_x,
  output logic [OPW-1:0]   mul_y,
  input  logic [PRODW-1:0] mul_product,
  input  logic             mul_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [3:0]       out_count,
  output logic             out_err
);

  localparam int unsigned PadW    = ACC_W - PRODW;
  localparam logic [3:0]  CntLast = 4'(N_MAX - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [OPW-1:0]   r_x;
  logic [OPW-1:0]   r_y;
  logic             r_last;
  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_count;
  logic [ACC_W-1:0] w_term;
  logic             w_timeout;
  logic             w_clr;

`ifdef MAC_WATCHDOG_EN
  logic r_err;
  logic r_abort;

  mac_watchdog u_wdog (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_clr     (r_state != StWait),
    .i_en      (r_state == StWait),
    .o_timeout (w_timeout)
  );

  // Sticky error per vector; abort flag zeroes the contribution of a timed-out term.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      if (r_state == StWait && !mul_ready && w_timeout) begin
        r_err   <= 1'b1;
        r_abort <= 1'b1;
      end else if (r_state == StAcc) begin
        r_abort <= 1'b0;
      end
      if (r_state == StDone && out_ready) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_err = r_err;
  assign w_term  = r_abort ? '0 : {{PadW{1'b0}}, mul_product};
`else
  assign w_timeout = 1'b0;
  assign out_err   = 1'b0;
  assign w_term    = {{PadW{1'b0}}, mul_product};
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_clr        = 1'b0;
    mul_start    = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StClr;
      end
      StClr: begin
        w_clr        = 1'b1;
        w_state_next = StStart;
      end
      StStart: begin
        mul_start    = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        if (mul_ready || w_timeout) w_state_next = StAcc;
      end
      StAcc: begin
        w_state_next = (r_last || (r_count == CntLast)) ? StDone : StIdle;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture and accumulation; cleared once the result is consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_last  <= 1'b0;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_x    <= in_x;
            r_y    <= in_y;
            r_last <= in_last;
          end
        end
        StAcc: begin
          r_acc   <= r_acc + w_term;
          r_count <= r_count + 4'd1;
        end
        StDone: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Multiplier is held cleared throughout reset as well as in CLR.
  assign mul_reset = w_clr | ~reset;
  assign mul_x     = r_x;
  assign mul_y     = r_y;
  assign out_sum   = r_acc;
  assign out_count = r_count;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: randomized pairs, reference dot-product model,
// scoreboard queue and a behavioural Booth-multiplier stand-in.
module tb_mac_sequencer;

  localparam int unsigned N_MAX = 8;
  localparam int unsigned ACC_W = 24;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [3:0]       cnt;
    logic             err;
  } res_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_x = '0;
  logic [7:0]       in_y = '0;
  logic             in_last = 1'b0;
  logic             mul_reset;
  logic             mul_start;
  logic [7:0]       mul_x;
  logic [7:0]       mul_y;
  logic [15:0]      mdl_prod;
  logic             mdl_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [3:0]       out_count;
  logic             out_err;

  mac_sequencer #(.N_MAX(N_MAX), .ACC_W(ACC_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_last     (in_last),
    .mul_reset   (mul_reset),
    .mul_start   (mul_start),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_product (mdl_prod),
    .mul_ready   (mdl_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .out_err     (out_err)
  );

  initial forever #5 clock = ~clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_clr   = 0;
  int   n_start = 0;
  bit   rand_ready = 1'b0;
  bit   stuck = 1'b0;
  res_t exp_q[$];

  // Reference model state: running dot product of the open vector.
  longint m_sum = 0;
  int     m_cnt = 0;
  bit     m_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural multiplier: sticky ready, cleared by mul_reset, 13..28 cycle latency.
  logic [7:0] mdl_x, mdl_y;
  logic       mdl_busy;
  int         mdl_cnt;
  always @(posedge clock) begin
    if (mul_reset) begin
      mdl_ready <= 1'b0;
      mdl_prod  <= '0;
      mdl_busy  <= 1'b0;
    end else if (mul_start) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= $urandom_range(12, 27);
      mdl_x    <= mul_x;
      mdl_y    <= mul_y;
    end else if (mdl_busy && !stuck) begin
      if (mdl_cnt == 0) begin
        mdl_busy  <= 1'b0;
        mdl_ready <= 1'b1;
        mdl_prod  <= 16'(mdl_x) * 16'(mdl_y);
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // Random back-pressure when enabled.
  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: strobe rules, operand stability, result hold and scoreboard compare.
  initial begin
    bit   hold_prev = 1'b0;
    res_t held;
    res_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold_prev = 1'b0;
      end else begin
        if (mul_reset) n_clr++;
        if (mul_start) begin
          n_start++;
          check("start_excl_reset", mul_reset, 0);
        end
        if (mdl_busy && !mul_reset) check("mul_x_stable", mul_x, mdl_x);
        if (mdl_busy && !mul_reset) check("mul_y_stable", mul_y, mdl_y);
        if (out_valid) begin
          check("in_ready_in_done", in_ready, 0);
          if (hold_prev) begin
            check("hold_sum", out_sum, held.sum);
            check("hold_count", out_count, held.cnt);
            check("hold_err", out_err, held.err);
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_result", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("out_sum", out_sum, e.sum);
              check("out_count", out_count, e.cnt);
              check("out_err", out_err, e.err);
            end
          end
        end
        hold_prev = out_valid && !out_ready;
        held      = '{sum: out_sum, cnt: out_count, err: out_err};
      end
    end
  end

  task automatic model_clear();
    m_sum = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Offer one pair, wait (bounded) for acceptance, then update the reference model.
  task automatic send_pair(input logic [7:0] x, input logic [7:0] y, input bit last,
                           input bit stk);
    int   n = 0;
    res_t e;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("accept_wait_expired", (n >= 300) ? 1 : 0, 0);
    stuck = stk;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    m_cnt++;
    if (stk) m_err = 1'b1;
    else m_sum += longint'(x) * longint'(y);
    if (last || m_cnt == N_MAX) begin
      e.sum = m_sum[ACC_W-1:0];
      e.cnt = 4'(m_cnt);
      e.err = m_err;
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_expired", (n >= 3000) ? 1 : 0, 0);
  endtask

  initial begin
    int n;
    #3 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_reset", mul_reset, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_x", mul_x, 0);
    check("rst_mul_y", mul_y, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_err", out_err, 0);
    reset = 1'b1;

    // Single term: exactly one clear and one start pulse.
    n_clr = 0;
    n_start = 0;
    send_pair(8'd3, 8'd5, 1'b1, 1'b0);
    drain();
    check("t1_clr_pulses", n_clr, 1);
    check("t1_start_pulses", n_start, 1);

    // Four max-value terms.
    for (int i = 0; i < 4; i++) send_pair(8'd255, 8'd255, i == 3, 1'b0);
    drain();

    // Nine terms without last: forced closure at N_MAX, ninth opens a new vector.
    for (int i = 0; i < 9; i++) send_pair(8'd1, 8'd2, 1'b0, 1'b0);
    send_pair(8'd0, 8'd0, 1'b1, 1'b0);
    drain();

    // Long back-pressure: result held and input blocked.
    out_ready = 1'b0;
    send_pair(8'd10, 8'd20, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("t4_valid_wait_expired", (n >= 200) ? 1 : 0, 0);
    repeat (20) @(posedge clock);
    #1;
    check("t4_still_valid", out_valid, 1);
    out_ready = 1'b1;
    drain();

    // Reset during WAIT of term 2: partial vector discarded.
    send_pair(8'd1, 8'd1, 1'b0, 1'b0);
    send_pair(8'd2, 8'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    check("t5_mul_reset", mul_reset, 1);
    check("t5_out_valid", out_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    send_pair(8'd7, 8'd9, 1'b1, 1'b0);
    drain();

`ifdef MAC_WATCHDOG_EN
    // Stuck multiplier: term aborted, counted, contributes 0, err flagged.
    send_pair(8'd4, 8'd4, 1'b0, 1'b1);
    send_pair(8'd2, 8'd3, 1'b1, 1'b0);
    drain();
`endif

    // Randomized vectors with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                $urandom_range(0, 3) == 0, 1'b0);
    end
    send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clock);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Operand sequencer and accumulator for the radix-4 Booth multiplier. It accepts a stream of unsigned 8-bit operand pairs, drives one multiplier instance per pair (clear, start, wait for ready), and sums the 16-bit products into a dot-product result. One result is emitted per vector, terminated by `in_last` or by reaching `N_MAX` terms. It sits directly upstream and downstream of the multiplier.

## Interface
Parameters:
- `N_MAX`, 8: maximum terms per vector (2..15).
- `ACC_W`, 24: accumulator and result width. Must be at least 16 + clog2(N_MAX).

Ports:
- `clock`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: sequencer can accept a pair.
- `in_x`, input, 8: multiplier operand x, unsigned.
- `in_y`, input, 8: multiplier operand y, unsigned.
- `in_last`, input, 1: this pair ends the vector.
- `mul_reset`, output, 1: synchronous active-high clear to the multiplier.
- `mul_start`, output, 1: start pulse to the multiplier.
- `mul_x`, output, 8: registered x, held stable during a multiply.
- `mul_y`, output, 8: registered y, held stable during a multiply.
- `mul_product`, input, 16: multiplier product, unsigned.
- `mul_ready`, input, 1: multiplier done. Sticky until `mul_reset`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, ACC_W: dot-product result.
- `out_count`, output, 4: number of terms in the result (1..N_MAX).
- `out_err`, output, 1: a watchdog timeout occurred in this vector. Tied to 0 without the macro.

## Operation
States: IDLE, CLR, START, WAIT, ACC, DONE.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `in_x`/`in_y` into `mul_x`/`mul_y`, latch `in_last`, then go to CLR.
- **CLR**
  - `mul_reset`=1 for one cycle. This clears the multiplier's sticky `ready` and its accumulated product.
  - Go to START.
- **START**
  - `mul_start`=1 for one cycle.
  - Go to WAIT.
- **WAIT**
  - Hold `mul_x`/`mul_y`; the multiplier reads them every cycle.
  - On `mul_ready`=1, go to ACC.
- **ACC**
  - acc <= acc + zero-extended `mul_product`; count <= count + 1.
  - If the latched last is set, or count+1 == N_MAX, go to DONE. Otherwise go to IDLE.
- **DONE**
  - `out_valid`=1 with `out_sum`=acc, `out_count`=count, `out_err`=err.
  - Outputs are held stable until `out_ready`.
  - On `out_valid`&&`out_ready`: clear acc, count and err, then go to IDLE.
  - `in_ready`=0 while in DONE, so no new vector starts before the result is consumed.

Rules:
- Accumulation wraps modulo 2^ACC_W. With the default parameters it cannot overflow.
- Forced closure at N_MAX: the vector ends even if `in_last`=0. The next pair starts a new vector.
- `in_last` asserted on the N_MAX-th pair produces a single closure, not two.
- `mul_reset` and `mul_start` are never high in the same cycle.

Reset values (while `reset`=0):
- State IDLE; `in_ready`=1.
- `mul_reset`=1, so the multiplier is held cleared for the whole reset.
- `mul_start`=0; `mul_x`=`mul_y`=0.
- `out_valid`=0; `out_sum`=0; `out_count`=0; `out_err`=0.
- acc, count and err are cleared.

Reset mid-operation: any state returns to IDLE and the partial vector is discarded. There is no output for it.

## Timing
- Pair accept edge to CLR: 1 cycle. CLR, START and ACC are 1 cycle each.
- WAIT lasts until `mul_ready`. The multiplier takes 13..28 cycles after its start edge, depending on x.
- Per-term overhead beyond the multiplier is 4 cycles (IDLE, CLR, START, ACC).
- The result appears 1 cycle after the ACC of the final term.
- Throughput: at most one pair per multiply. `in_ready` is high only in IDLE.
- `out_valid` to `out_ready` back-pressure has unbounded length.

## Configuration
Macro `MAC_WATCHDOG_EN`.

- **Defined:**
  - A 6-bit counter runs in WAIT.
  - When it reaches 63 with `mul_ready` still 0, the term is aborted and contributes 0.
  - The term still counts toward count.
  - The sticky err bit is set, and the state goes to ACC-equivalent handling.
  - `out_err` reports err with the result.
- **Undefined:**
  - There is no counter; WAIT waits indefinitely.
  - `out_err` is constant 0.

## Structure
- Package `mac_seq_pkg` holds:
  - the state enum;
  - `WDOG_LIMIT` = 63;
  - operand width 8 and product width 16 constants.
- Sub-module `mac_watchdog` contains the clear/enable/timeout counter. It is instantiated only under `MAC_WATCHDOG_EN`.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
1. Single pair x=3, y=5, `in_last`=1 → `out_sum`=15, `out_count`=1, `out_err`=0, with exactly one `mul_reset` pulse and one `mul_start` pulse.
2. Four pairs (255,255), last on the 4th → `out_sum`=260100, `out_count`=4.
3. Nine pairs (1,2) with no last → first result `out_sum`=16, `out_count`=8; the 9th pair begins a new vector.
4. `out_ready` held 0 for 20 cycles after `out_valid` → result stable, `in_ready`=0 throughout, then accepted on `out_ready`.
5. `reset` pulled low during WAIT of term 2 → `mul_reset`=1 and `out_valid`=0. After release, pair (7,9) last → `out_sum`=63.
6. `MAC_WATCHDOG_EN` defined, `mul_ready` stuck at 0 for pair (4,4), then pair (2,3) last → after 63 WAIT cycles, result `out_sum`=6, `out_count`=2, `out_err`=1.
